// File: rtl/fifo_pkt_rd_ctrl_if.sv
// fifo_pkt_rd_ctrl_if: read-side FIFO, UDP transmitter and status signals of
// the packet read controller.
//   master : the controller (drives fifo_rd_en, tx_start_en, tx_byte_num,
//            tx_data, busy, pkt_cnt, underflow)
//   slave  : FIFO + transmitter + status observer side
interface fifo_pkt_rd_ctrl_if;
  localparam int unsigned CNT_W  = 11;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned LEN_W  = 16;

  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_rd_count;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_rd_en;
  logic              tx_start_en;
  logic [LEN_W-1:0]  tx_byte_num;
  logic              tx_req;
  logic [DATA_W-1:0] tx_data;
  logic              tx_done;
  logic              busy;
  logic [LEN_W-1:0]  pkt_cnt;
  logic              underflow;

  modport master (
    input  fifo_empty, fifo_rd_count, fifo_dout, tx_req, tx_done,
    output fifo_rd_en, tx_start_en, tx_byte_num, tx_data, busy, pkt_cnt,
           underflow
  );

  modport slave (
    output fifo_empty, fifo_rd_count, fifo_dout, tx_req, tx_done,
    input  fifo_rd_en, tx_start_en, tx_byte_num, tx_data, busy, pkt_cnt,
           underflow
  );
endinterface

// File: rtl/fifo_pkt_rd_ctrl.sv
// fifo_pkt_rd_ctrl: drains a byte FIFO into a UDP transmitter frame by frame.
// A frame of PKT_LEN bytes is started once the FIFO holds that many. With
// FIFO_RD_TIMEOUT_EN defined, a partial frame holding whatever is in the
// FIFO is flushed after TIMEOUT idle cycles with a non-empty FIFO.
// Ports:
//   clk  : FIFO read-side clock
//   rst  : asynchronous active-high reset
//   bus  : fifo_pkt_rd_ctrl_if.master
//          fifo_empty/fifo_rd_count/fifo_dout in, fifo_rd_en out
//          tx_req/tx_done in, tx_start_en/tx_byte_num/tx_data out
//          busy/pkt_cnt/underflow status out
// fifo_rd_en and tx_data are combinational (tx_req-to-data latency of one
// cycle, read data comes straight from the FIFO); all other outputs are
// registered.
module fifo_pkt_rd_ctrl #(
  parameter int unsigned PKT_LEN = 1024,
  parameter int unsigned TIMEOUT = 1000
) (
  input logic              clk,
  input logic              rst,
  fifo_pkt_rd_ctrl_if.master bus
);

  localparam int unsigned CNT_W = 11;
  localparam int unsigned LEN_W = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    SEND      = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] len;
  logic [CNT_W-1:0] rd_cnt;
  logic             tx_start_en_q;
  logic [LEN_W-1:0] tx_byte_num_q;
  logic             busy_q;
  logic [LEN_W-1:0] pkt_cnt_q;
  logic             underflow_q;

  logic full_c;
  logic rd_room_c;
  logic rd_en_c;
  logic tmo_hit_c;

  // Frame start conditions and read gating
  assign full_c    = bus.fifo_rd_count >= CNT_W'(PKT_LEN);
  assign rd_room_c = rd_cnt < len;
  assign rd_en_c   = (state == SEND) && bus.tx_req && rd_room_c && !bus.fifo_empty;

`ifdef FIFO_RD_TIMEOUT_EN
  // Counter holds 0..TIMEOUT-1; the flush fires on the TIMEOUT-th non-empty cycle
  localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TMO_W-1:0] tmo_cnt;

  assign tmo_hit_c = (state == IDLE) && !bus.fifo_empty && !full_c &&
                     (bus.fifo_rd_count != '0) &&
                     (tmo_cnt == TMO_W'(TIMEOUT - 1));

  // Idle timeout counter, cleared on empty FIFO or leaving IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if ((state != IDLE) || bus.fifo_empty || full_c || tmo_hit_c) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TMO_W'(TIMEOUT - 1)) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end
`else
  assign tmo_hit_c = 1'b0;
`endif

  // Frame FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      len           <= '0;
      rd_cnt        <= '0;
      tx_start_en_q <= 1'b0;
      tx_byte_num_q <= '0;
      busy_q        <= 1'b0;
      pkt_cnt_q     <= '0;
      underflow_q   <= 1'b0;
    end else begin
      tx_start_en_q <= 1'b0;
      case (state)
        IDLE: begin
          // Full frame takes priority over the partial-frame flush
          if (full_c) begin
            len           <= CNT_W'(PKT_LEN);
            tx_byte_num_q <= LEN_W'(PKT_LEN);
            rd_cnt        <= '0;
            tx_start_en_q <= 1'b1;
            busy_q        <= 1'b1;
            state         <= START;
          end else if (tmo_hit_c) begin
            len           <= bus.fifo_rd_count;
            tx_byte_num_q <= LEN_W'(bus.fifo_rd_count);
            rd_cnt        <= '0;
            tx_start_en_q <= 1'b1;
            busy_q        <= 1'b1;
            state         <= START;
          end
        end
        START: begin
          state <= SEND;
        end
        SEND: begin
          if (rd_en_c) begin
            rd_cnt <= rd_cnt + CNT_W'(1);
            if (rd_cnt == len - CNT_W'(1)) begin
              state <= WAIT_DONE;
            end
          end
          // Transmitter asked for a byte the FIFO cannot supply
          if (bus.tx_req && rd_room_c && bus.fifo_empty) begin
            underflow_q <= 1'b1;
          end
        end
        WAIT_DONE: begin
          if (bus.tx_done) begin
            pkt_cnt_q <= pkt_cnt_q + LEN_W'(1);
            busy_q    <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.fifo_rd_en  = rd_en_c;
  assign bus.tx_data     = bus.fifo_dout;
  assign bus.tx_start_en = tx_start_en_q;
  assign bus.tx_byte_num = tx_byte_num_q;
  assign bus.busy        = busy_q;
  assign bus.pkt_cnt     = pkt_cnt_q;
  assign bus.underflow   = underflow_q;

endmodule

// File: tb/tb_fifo_pkt_rd_ctrl.sv
// tb_fifo_pkt_rd_ctrl: directed bench for fifo_pkt_rd_ctrl with a behavioural
// FIFO and a byte scoreboard (bytes queued on write, popped as tx_data).
// Partial-frame flush checks follow FIFO_RD_TIMEOUT_EN.
module tb_fifo_pkt_rd_ctrl;

  localparam int unsigned PKT_LEN = 1024;
  localparam int unsigned TIMEOUT = 1000;

  logic clk = 1'b0;
  logic rst;

  fifo_pkt_rd_ctrl_if bus ();

  fifo_pkt_rd_ctrl #(.PKT_LEN(PKT_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  logic [7:0]  fifo_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  wr_pat;
  logic [15:0] exp_pkt;
  logic [15:0] start_len;
  bit          force_empty;
  bit          rd_pending;
  int          rd_total;
  int          start_cnt;
  int          tests;
  int          fails;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void upd_flags();
    bus.fifo_rd_count = 11'(fifo_q.size());
    bus.fifo_empty    = force_empty || (fifo_q.size() == 0);
  endfunction

  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(wr_pat);
      exp_q.push_back(wr_pat);
      wr_pat = wr_pat + 8'd1;
    end
    upd_flags();
  endtask

  task automatic flush();
    fifo_q.delete();
    exp_q.delete();
    upd_flags();
  endtask

  // One clock: sample the read strobe before the edge, return FIFO data after it
  task automatic cyc();
    logic [7:0] exp_b;
    #1;
    rd_pending = bus.fifo_rd_en;
    @(negedge clk);
    if (rd_pending) begin
      rd_total++;
      if (fifo_q.size() > 0) bus.fifo_dout = fifo_q.pop_front();
      upd_flags();
    end
    #1;
    if (rd_pending) begin
      exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      chk("tx_data", 32'(bus.tx_data), 32'(exp_b));
    end
    if (bus.tx_start_en === 1'b1) begin
      start_cnt++;
      start_len = bus.tx_byte_num;
    end
  endtask

  task automatic begin_frame();
    rd_total    = 0;
    start_cnt   = 0;
    bus.tx_req  = 1'b1;
  endtask

  task automatic run_until(input int target, input string tag);
    int n;
    n = 0;
    while (rd_total < target && n < target + 64) begin
      cyc();
      n++;
    end
    chk(tag, 32'(rd_total), 32'(target));
  endtask

  task automatic end_frame(input int len_exp);
    repeat (3) cyc();
    chk("no_read_after_len", 32'(rd_total), 32'(len_exp));
    chk("start_pulses", 32'(start_cnt), 32'd1);
    chk("tx_byte_num", 32'(start_len), 32'(len_exp));
    chk("busy_wait_done", 32'(bus.busy), 32'd1);
    bus.tx_done = 1'b1;
    cyc();
    bus.tx_done = 1'b0;
    bus.tx_req  = 1'b0;
    exp_pkt     = exp_pkt + 16'd1;
    chk("busy_after_done", 32'(bus.busy), 32'd0);
    chk("pkt_cnt", 32'(bus.pkt_cnt), 32'(exp_pkt));
  endtask

  initial begin
    int t_start;
    tests       = 0;
    fails       = 0;
    wr_pat      = 8'h00;
    exp_pkt     = 16'd0;
    force_empty = 1'b0;
    rd_total    = 0;
    start_cnt   = 0;
    start_len   = 16'd0;
    rst         = 1'b1;
    bus.tx_req  = 1'b1;
    bus.tx_done = 1'b0;
    bus.fifo_dout = 8'hA5;
    upd_flags();

    // Reset values
    @(negedge clk);
    #1;
    chk("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    chk("rst_start", 32'(bus.tx_start_en), 32'd0);
    chk("rst_byte_num", 32'(bus.tx_byte_num), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_pkt_cnt", 32'(bus.pkt_cnt), 32'd0);
    chk("rst_underflow", 32'(bus.underflow), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'h0000_00A5);
    cyc();
    rst        = 1'b0;
    bus.tx_req = 1'b0;
    cyc();

    // Full 1024-byte frame, 0x00..0xFF repeating
    begin_frame();
    push(1024);
    run_until(1024, "full_frame_reads");
    end_frame(1024);

    // tx_done outside WAIT_DONE is ignored
    bus.tx_done = 1'b1;
    cyc();
    bus.tx_done = 1'b0;
    cyc();
    chk("idle_tx_done_ignored", 32'(bus.pkt_cnt), 32'(exp_pkt));

`ifdef FIFO_RD_TIMEOUT_EN
    // Partial frame flushed after TIMEOUT non-empty idle cycles
    begin_frame();
    push(1);
    t_start = 0;
    for (int k = 1; k <= 1200 && t_start == 0; k++) begin
      cyc();
      if (start_cnt != 0) t_start = k;
      if (k < 10) push(1);
    end
    chk("timeout_latency", 32'(t_start), 32'(TIMEOUT));
    run_until(10, "partial_frame_reads");
    end_frame(10);
`else
    // No flush of a partial frame
    begin_frame();
    for (int k = 0; k < 10; k++) begin
      push(1);
      cyc();
    end
    repeat (5000) cyc();
    chk("no_partial_start", 32'(start_cnt), 32'd0);
    chk("no_partial_busy", 32'(bus.busy), 32'd0);
    chk("no_partial_reads", 32'(rd_total), 32'd0);
    bus.tx_req = 1'b0;
    flush();
    cyc();
    t_start = 0;
`endif

    // Underflow: FIFO reports empty at byte 500 while tx_req stays high
    begin_frame();
    push(1024);
    run_until(500, "uf_pre_reads");
    force_empty = 1'b1;
    upd_flags();
    cyc();
    chk("uf_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    chk("uf_flag", 32'(bus.underflow), 32'd1);
    repeat (4) cyc();
    chk("uf_rd_cnt_hold", 32'(dut.rd_cnt), 32'd500);
    chk("uf_reads_hold", 32'(rd_total), 32'd500);
    force_empty = 1'b0;
    upd_flags();
    run_until(1024, "uf_post_reads");
    end_frame(1024);
    chk("uf_sticky", 32'(bus.underflow), 32'd1);

    // Reset in SEND at byte 300
    begin_frame();
    push(1024);
    run_until(300, "rst_pre_reads");
    rst = 1'b1;
    #1;
    chk("midrst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_pkt_cnt", 32'(bus.pkt_cnt), 32'd0);
    chk("midrst_underflow", 32'(bus.underflow), 32'd0);
    flush();
    cyc();
    cyc();
    chk("midrst_no_reads", 32'(rd_total), 32'd300);
    rst        = 1'b0;
    bus.tx_req = 1'b0;
    exp_pkt    = 16'd0;
    cyc();
    begin_frame();
    push(1024);
    run_until(1024, "restart_reads");
    end_frame(1024);

    // pkt_cnt wrap from 0xFFFF
    force dut.pkt_cnt_q = 16'hFFFF;
    cyc();
    release dut.pkt_cnt_q;
    cyc();
    chk("preset_pkt_cnt", 32'(bus.pkt_cnt), 32'h0000_FFFF);
    exp_pkt = 16'hFFFF;
    begin_frame();
    push(1024);
    run_until(1024, "wrap_reads");
    end_frame(1024);
    chk("pkt_cnt_wrap", 32'(bus.pkt_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_pkt_rd_ctrl.md
FIFO_PKT_RD_CTRL -- requirements
Module: fifo_pkt_rd_ctrl

Interface
REQ-001 SHALL have parameter PKT_LEN, default 1024, full-frame payload length in bytes (1..2047).
REQ-002 SHALL have parameter TIMEOUT, default 1000, number of idle clk cycles with non-empty FIFO before a partial frame is flushed.
REQ-003 SHALL have port clk  input  1  single clock, the FIFO read-side clock.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port fifo_empty  input  1  FIFO empty flag.
REQ-006 SHALL have port fifo_rd_count  input  11  FIFO read-side occupancy in bytes.
REQ-007 SHALL have port fifo_dout  input  8  FIFO read data, valid one cycle after fifo_rd_en.
REQ-008 SHALL have port fifo_rd_en  output  1  FIFO read strobe.
REQ-009 SHALL have port tx_start_en  output  1  one-cycle frame-start pulse to the UDP transmitter.
REQ-010 SHALL have port tx_byte_num  output  16  payload length of the current frame.
REQ-011 SHALL have port tx_req  input  1  UDP transmitter byte request; the byte is expected on tx_data the following cycle.
REQ-012 SHALL have port tx_data  output  8  payload byte to the transmitter.
REQ-013 SHALL have port tx_done  input  1  one-cycle pulse marking the end of frame transmission.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port pkt_cnt  output  16  number of frames completed; wraps from 0xFFFF to 0.
REQ-016 SHALL have port underflow  output  1  sticky error flag.

Function
REQ-017 SHALL implement the FSM states IDLE, START, SEND and WAIT_DONE.
REQ-018 IDLE SHALL latch len = PKT_LEN and go to START when fifo_rd_count >= PKT_LEN; this condition takes priority over timeout.
REQ-019 IDLE SHALL run a timeout counter while fifo_empty = 0 and clear it when fifo_empty = 1 or on leaving IDLE.
REQ-020 When the timeout counter reaches TIMEOUT with 0 < fifo_rd_count < PKT_LEN, IDLE SHALL latch len = fifo_rd_count and go to START.
REQ-021 START SHALL assert tx_start_en for exactly 1 cycle with tx_byte_num = len, then go to SEND.
REQ-022 tx_byte_num SHALL hold len from START until return to IDLE.
REQ-023 In SEND, fifo_rd_en SHALL equal tx_req & (rd_cnt < len) & !fifo_empty.
REQ-024 In SEND, rd_cnt SHALL increment on each fifo_rd_en, and the FSM SHALL go to WAIT_DONE on the cycle rd_cnt reaches len.
REQ-025 tx_data SHALL be fifo_dout passed through combinationally, giving 1-cycle tx_req-to-data latency.
REQ-026 In SEND, tx_req with fifo_empty = 1 SHALL suppress the read and set underflow, which stays set until reset.
REQ-027 tx_req arriving after rd_cnt = len SHALL be ignored, with no read issued.
REQ-028 WAIT_DONE SHALL go to IDLE on tx_done and increment pkt_cnt in the same cycle.
REQ-029 tx_done received in any state other than WAIT_DONE SHALL be ignored.
REQ-030 fifo_rd_en SHALL never be asserted outside SEND.
REQ-031 rd_cnt SHALL be 11 bits wide, and len SHALL be zero-extended onto tx_byte_num.

Reset
REQ-032 While rst = 1, all outputs SHALL be 0 (tx_data follows fifo_dout), the FSM SHALL be in IDLE, and the counters and len SHALL be 0.
REQ-033 Reset asserted mid-frame SHALL abort immediately with no further reads; FIFO flushing is the owner's responsibility.

Configuration
REQ-034 With FIFO_RD_TIMEOUT_EN defined, the timeout flush of REQ-019/REQ-020 SHALL be present.
REQ-035 Without FIFO_RD_TIMEOUT_EN, the timeout counter SHALL be absent and only full PKT_LEN frames SHALL be sent.

Verification
REQ-036 Fill 1024 bytes (0x00..0xFF repeating), tx_req continuous -> single tx_start_en with tx_byte_num = 1024, 1024 reads, tx_data in order, pkt_cnt = 1 after tx_done.
REQ-037 With the macro defined, write 10 bytes and wait -> tx_start_en 1000 cycles after non-empty, tx_byte_num = 10, exactly 10 reads.
REQ-038 Without the macro, write 10 bytes and wait 5000 cycles -> no tx_start_en and busy = 0.
REQ-039 Force fifo_empty = 1 at byte 500 of a 1024-byte frame while tx_req = 1 -> read suppressed, underflow = 1, rd_cnt holds at 500.
REQ-040 Assert rst in SEND at byte 300 -> same cycle fifo_rd_en = 0, busy = 0, pkt_cnt = 0; a later 1024-byte fill restarts normally.
REQ-041 Preset pkt_cnt = 0xFFFF via repeated frames, complete one more -> pkt_cnt = 0x0000.
